aq_f_spsram_init: RTL and testbench
===================================

Name: aq_f_spsram_init

Overview:
- Parametrised FPGA single-port SRAM model with a bit-level write mask and a selectable read latency of 1 or 2 cycles.
- Contains a built-in initialisation sweep: after reset, or on request, it writes INIT_VAL to every entry.
- Replaces fixed-size SRAM wrappers wherever arrays must start from a known value, such as tag, valid and LRU arrays.
- Active-low control semantics are unchanged from the existing SRAM macros.

Parameters:
- ADDR_WIDTH, 7: address bits. DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 8: word width in bits.
- READ_LAT, 1: read latency in cycles. Legal values are 1 and 2; any other value is an elaboration error.
- INIT_EN, 1: 1 = run the init sweep on reset release; 0 = come out of reset in IDLE.
- INIT_VAL, 0: DATA_WIDTH-bit value written by the sweep.

Ports:
- CLK  input  1  clock; all logic is on the rising edge.
- RST_B  input  1  reset; synchronous, active-low.
- A  input  ADDR_WIDTH  access address.
- CEN  input  1  chip enable, active-low.
- GWEN  input  1  global write enable, active-low. 0 = write, 1 = read.
- WEN  input  DATA_WIDTH  per-bit write enable, active-low.
- D  input  DATA_WIDTH  write data.
- INIT_REQ  input  1  single-cycle request to re-run the init sweep.
- Q  output  DATA_WIDTH  read data.
- Q_VLD  output  1  one-cycle pulse: Q was updated this cycle.
- INIT_BUSY  output  1  high while the sweep runs.

Behaviour:
- Clocking and reset: one clock, CLK. Reset RST_B is synchronous and active-low.
- Memory array:
  - DEPTH x DATA_WIDTH, inferable as FPGA block/distributed RAM.
  - Contents are never touched by reset; they change only through writes or the sweep.
- State machine, two states IDLE and INIT:
  - While RST_B=0: state <= INIT if INIT_EN=1, else IDLE. Also init counter <= 0, Q <= 0, Q_VLD <= 0, pipeline stage valid <= 0.
  - INIT, every cycle: mem[cnt] <= INIT_VAL and cnt <= cnt+1. After the cycle that writes DEPTH-1, go to IDLE and return cnt to 0. The sweep takes exactly DEPTH cycles.
  - IDLE with INIT_REQ=1: go to INIT on the next edge. cnt starts at 0.
  - INIT_REQ while in INIT is ignored; the sweep does not restart.
  - INIT_BUSY = (state==INIT). It is registered, with no combinational path from inputs.
  - Reset asserted mid-sweep: counter returns to 0. If INIT_EN=1 the sweep restarts from address 0 after release.
- User access is accepted only when state==IDLE and CEN=0. In INIT all user inputs are ignored: no write, no read, Q holds, Q_VLD=0.
- Write (accepted, GWEN=0):
  - For each bit i with WEN[i]=0: mem[A][i] <= D[i]. Bits with WEN[i]=1 are unchanged.
  - WEN all ones is a legal no-op write.
  - A write never updates Q and never raises Q_VLD.
- Read (accepted, GWEN=1): WEN and D are don't-care.
  - READ_LAT=1: Q <= mem[A] at the edge ending the request cycle. Q_VLD=1 for the following cycle.
  - READ_LAT=2: an intermediate data register plus valid bit capture mem[A]. Q and Q_VLD follow one cycle later.
  - Back-to-back reads are fully pipelined: one result per cycle, in order.
- Read-after-write to the same address on consecutive cycles returns the newly written data.
- Q holds its last read value indefinitely when no read completes, including during and after a sweep. A sweep does not alter Q.
- Sweep requested while a READ_LAT=2 read is in flight: the in-flight read still completes with its pre-sweep data.
- Addresses are always in range (full power-of-two decode); there is no wrap logic.

Test Plan:
- Reset sweep: INIT_EN=1, ADDR_WIDTH=7, INIT_VAL=8'hA5; hold RST_B=0 for 3 cycles, then release -> INIT_BUSY=1 for exactly 128 cycles, then 0. Reading addresses 0, 64 and 127 returns 8'hA5 with Q_VLD pulses. Q=0 before the first read.
- Masked write: write A=5, D=8'hFF, WEN=8'h00; then A=5, D=8'h00, WEN=8'hF0; then read A=5 -> Q=8'hF0.
- Latency: READ_LAT=2; reads of addresses 1, 2, 3 on consecutive cycles (preloaded 8'h11, 8'h22, 8'h33) -> Q shows 11, 22, 33 on cycles +2, +3, +4, with Q_VLD high for 3 cycles. Repeat with READ_LAT=1 -> results appear at +1, +2, +3.
- Busy lockout: pulse INIT_REQ (INIT_VAL=0), then write A=9, D=8'h3C during INIT_BUSY -> after the sweep, reading A=9 gives 8'h00, and Q is unchanged throughout the sweep.
- Reset mid-sweep: assert RST_B=0 at sweep cycle 50, release 2 cycles later -> a full 128-cycle INIT_BUSY window restarting at address 0. Pulsing INIT_REQ during the sweep does not extend it.
- Hold/RAW: read A=7 -> 8'h12; idle 10 cycles -> Q stays 8'h12 and Q_VLD=0. Write A=7, D=8'h34, then read A=7 next cycle -> Q=8'h34.

Source files
------------

// File: rtl/aq_f_spsram_init_if.sv
// Access bus of the initialising single-port SRAM: user requests in, read data and status out.
interface aq_f_spsram_init_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] A;
  logic                  CEN;
  logic                  GWEN;
  logic [DATA_WIDTH-1:0] WEN;
  logic [DATA_WIDTH-1:0] D;
  logic                  INIT_REQ;
  logic [DATA_WIDTH-1:0] Q;
  logic                  Q_VLD;
  logic                  INIT_BUSY;

  modport master (
    output A, CEN, GWEN, WEN, D, INIT_REQ,
    input  Q, Q_VLD, INIT_BUSY
  );

  modport slave (
    input  A, CEN, GWEN, WEN, D, INIT_REQ,
    output Q, Q_VLD, INIT_BUSY
  );
endinterface

// File: rtl/aq_f_spsram_init.sv
// Single-port SRAM with bit-level write mask, 1- or 2-cycle read latency and a
// built-in sweep that fills every entry with INIT_VAL after reset or on request.
module aq_f_spsram_init #(
  parameter int                    ADDR_WIDTH = 7,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    READ_LAT   = 1,
  parameter int                    INIT_EN    = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input logic                CLK,
  input logic                RST_B,
  aq_f_spsram_init_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    INIT = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    userAcc;
  logic                    rdAcc;
  logic                    wrAcc;
  logic                    memWe;
  logic [ADDR_WIDTH-1:0]   wrAddr;
  logic [DATA_WIDTH-1:0]   wrData;
  logic [DATA_WIDTH-1:0]   rdData;
  logic [DATA_WIDTH-1:0]   q_q;
  logic                    qVld_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.INIT_REQ) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      INIT: begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (&cnt_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      state_q <= (INIT_EN != 0) ? INIT : IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset never touches the array, so all array activity is gated by RST_B.
  assign userAcc = RST_B && (state_q == IDLE) && !bus.CEN;
  assign rdAcc   = userAcc && bus.GWEN;
  assign wrAcc   = userAcc && !bus.GWEN;
  assign memWe   = RST_B && ((state_q == INIT) || wrAcc);
  assign wrAddr  = (state_q == INIT) ? cnt_q : bus.A;
  assign rdData  = mem[bus.A];
  assign wrData  = (state_q == INIT) ? INIT_VAL
                                     : ((rdData & bus.WEN) | (bus.D & ~bus.WEN));

  always_ff @(posedge CLK) begin
    if (memWe) begin
      mem[wrAddr] <= wrData;
    end
  end

  if (READ_LAT == 1) begin : gRd1
    always_ff @(posedge CLK) begin
      if (!RST_B) begin
        q_q    <= '0;
        qVld_q <= 1'b0;
      end else begin
        qVld_q <= rdAcc;
        if (rdAcc) begin
          q_q <= rdData;
        end
      end
    end
  end else if (READ_LAT == 2) begin : gRd2
    logic [DATA_WIDTH-1:0] s1Data_q;
    logic                  s1Vld_q;

    // The second stage drains regardless of state, so a read in flight when a sweep starts still lands.
    always_ff @(posedge CLK) begin
      if (!RST_B) begin
        s1Vld_q <= 1'b0;
        q_q     <= '0;
        qVld_q  <= 1'b0;
      end else begin
        s1Vld_q <= rdAcc;
        if (rdAcc) begin
          s1Data_q <= rdData;
        end
        qVld_q <= s1Vld_q;
        if (s1Vld_q) begin
          q_q <= s1Data_q;
        end
      end
    end
  end else begin : gRdBad
    $error("aq_f_spsram_init: READ_LAT must be 1 or 2");
  end

  assign bus.Q         = q_q;
  assign bus.Q_VLD     = qVld_q;
  assign bus.INIT_BUSY = (state_q == INIT);
endmodule

// File: tb/tb_aq_f_spsram_init.sv
// Bench for aq_f_spsram_init: two instances (1-cycle latency / INIT_VAL A5, 2-cycle latency / INIT_VAL 00)
// driven by identical stimulus and checked against plan constants and a behavioural model.
module tb_aq_f_spsram_init;
  localparam int AW    = 7;
  localparam int DW    = 8;
  localparam int DEPTH = 128;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } pend_t;

  logic          CLK = 1'b0;
  logic          RST_B = 1'b0;
  logic [AW-1:0] a = '0;
  logic          cen = 1'b1;
  logic          gwen = 1'b1;
  logic [DW-1:0] wen = '1;
  logic [DW-1:0] d = '0;
  logic          initReq = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model state: index 0 = 1-cycle / A5 instance, index 1 = 2-cycle / 00 instance
  logic [DW-1:0] mMem [2][DEPTH];
  int            mPos [2];
  logic [DW-1:0] mQ [2];
  logic          mQv [2];
  pend_t         pendQ [$];

  always #5 CLK = ~CLK;

  aq_f_spsram_init_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
  aq_f_spsram_init_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();

  assign bus1.A = a;       assign bus2.A = a;
  assign bus1.CEN = cen;   assign bus2.CEN = cen;
  assign bus1.GWEN = gwen; assign bus2.GWEN = gwen;
  assign bus1.WEN = wen;   assign bus2.WEN = wen;
  assign bus1.D = d;       assign bus2.D = d;
  assign bus1.INIT_REQ = initReq;
  assign bus2.INIT_REQ = initReq;

  aq_f_spsram_init #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LAT(1), .INIT_EN(1), .INIT_VAL(8'hA5)
  ) dut1 (
    .CLK(CLK), .RST_B(RST_B), .bus(bus1)
  );

  aq_f_spsram_init #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LAT(2), .INIT_EN(1), .INIT_VAL(8'h00)
  ) dut2 (
    .CLK(CLK), .RST_B(RST_B), .bus(bus2)
  );

  // Advances the model by one clock using the inputs that the DUT will sample at the coming edge.
  task automatic modelStep();
    logic [DW-1:0] v;
    logic [DW-1:0] rd;
    for (int k = 0; k < 2; k++) begin
      v = (k == 0) ? 8'hA5 : 8'h00;
      if (!RST_B) begin
        mPos[k] = 0;
        mQ[k]   = '0;
        mQv[k]  = 1'b0;
        if (k == 1) pendQ.delete();
      end else begin
        mQv[k] = 1'b0;
        if (k == 1 && pendQ.size() > 0 && pendQ[0].due == cyc) begin
          mQ[1]  = pendQ[0].data;
          mQv[1] = 1'b1;
          void'(pendQ.pop_front());
        end
        if (mPos[k] >= 0) begin
          mMem[k][mPos[k]] = v;
          mPos[k]++;
          if (mPos[k] == DEPTH) mPos[k] = -1;
        end else begin
          if (!cen) begin
            if (gwen) begin
              rd = mMem[k][a];
              if (k == 0) begin
                mQ[0]  = rd;
                mQv[0] = 1'b1;
              end else begin
                pendQ.push_back('{data: rd, due: cyc + 1});
              end
            end else begin
              for (int i = 0; i < DW; i++) begin
                if (!wen[i]) mMem[k][a][i] = d[i];
              end
            end
          end
          if (initReq) mPos[k] = 0;
        end
      end
    end
    cyc++;
  endtask

  task automatic tick();
    modelStep();
    @(posedge CLK);
    #1;
  endtask

  task automatic idleInputs();
    cen = 1'b1; gwen = 1'b1; wen = '1; d = '0; initReq = 1'b0;
  endtask

  task automatic test_reset();
    int n1, n2;
    int rdAddr [3];
    rdAddr = '{0, 64, 127};
    idleInputs();
    RST_B = 1'b0;
    repeat (3) tick();
    total++;
    if (bus1.Q !== 8'h00 || bus1.Q_VLD !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_q1: got Q=%h vld=%b want Q=00 vld=0", bus1.Q, bus1.Q_VLD);
    end
    total++;
    if (bus2.Q !== 8'h00 || bus2.Q_VLD !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_q2: got Q=%h vld=%b want Q=00 vld=0", bus2.Q, bus2.Q_VLD);
    end
    RST_B = 1'b1;
    n1 = 0; n2 = 0;
    while ((bus1.INIT_BUSY === 1'b1 || bus2.INIT_BUSY === 1'b1) && n1 < 400 && n2 < 400) begin
      if (bus1.INIT_BUSY === 1'b1) n1++;
      if (bus2.INIT_BUSY === 1'b1) n2++;
      tick();
    end
    total++;
    if (n1 != 128) begin bad++; $display("[TB] FAIL sweep_len1: got %0d want 128", n1); end
    total++;
    if (n2 != 128) begin bad++; $display("[TB] FAIL sweep_len2: got %0d want 128", n2); end
    total++;
    if (bus1.Q !== 8'h00 || bus2.Q !== 8'h00) begin
      bad++; $display("[TB] FAIL q_before_read: got %h/%h want 00/00", bus1.Q, bus2.Q);
    end
    for (int j = 0; j < 3; j++) begin
      a = AW'(rdAddr[j]); cen = 1'b0; gwen = 1'b1;
      tick();
      cen = 1'b1;
      total++;
      if (bus1.Q !== 8'hA5 || bus1.Q_VLD !== 1'b1) begin
        bad++; $display("[TB] FAIL init_rd1[%0d]: got Q=%h vld=%b want Q=a5 vld=1", rdAddr[j], bus1.Q, bus1.Q_VLD);
      end
      tick();
      total++;
      if (bus2.Q !== 8'h00 || bus2.Q_VLD !== 1'b1) begin
        bad++; $display("[TB] FAIL init_rd2[%0d]: got Q=%h vld=%b want Q=00 vld=1", rdAddr[j], bus2.Q, bus2.Q_VLD);
      end
    end
  endtask

  task automatic test_masked_write();
    a = 7'd5; cen = 1'b0; gwen = 1'b0; d = 8'hFF; wen = 8'h00;
    tick();
    d = 8'h00; wen = 8'hF0;
    tick();
    gwen = 1'b1; wen = '1;
    tick();
    cen = 1'b1;
    total++;
    if (bus1.Q !== 8'hF0 || bus1.Q_VLD !== 1'b1) begin
      bad++; $display("[TB] FAIL mask1: got Q=%h vld=%b want Q=f0 vld=1", bus1.Q, bus1.Q_VLD);
    end
    tick();
    total++;
    if (bus2.Q !== 8'hF0 || bus2.Q_VLD !== 1'b1) begin
      bad++; $display("[TB] FAIL mask2: got Q=%h vld=%b want Q=f0 vld=1", bus2.Q, bus2.Q_VLD);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp1Q [5];
    logic          exp1V [5];
    logic [DW-1:0] exp2Q [5];
    logic          exp2V [5];
    exp1Q = '{8'h11, 8'h22, 8'h33, 8'h33, 8'h33};
    exp1V = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp2Q = '{8'hF0, 8'h11, 8'h22, 8'h33, 8'h33};
    exp2V = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int j = 1; j <= 3; j++) begin
      a = AW'(j); cen = 1'b0; gwen = 1'b0; wen = 8'h00; d = DW'(j * 17);
      tick();
    end
    gwen = 1'b1; wen = '1; cen = 1'b1;
    tick();
    tick();
    for (int t = 0; t < 5; t++) begin
      if (t < 3) begin
        a = AW'(t + 1); cen = 1'b0; gwen = 1'b1;
      end else begin
        cen = 1'b1;
      end
      tick();
      total++;
      if (bus1.Q !== exp1Q[t] || bus1.Q_VLD !== exp1V[t]) begin
        bad++; $display("[TB] FAIL lat1_t%0d: got Q=%h vld=%b want Q=%h vld=%b", t + 1, bus1.Q, bus1.Q_VLD, exp1Q[t], exp1V[t]);
      end
      total++;
      if (bus2.Q !== exp2Q[t] || bus2.Q_VLD !== exp2V[t]) begin
        bad++; $display("[TB] FAIL lat2_t%0d: got Q=%h vld=%b want Q=%h vld=%b", t + 1, bus2.Q, bus2.Q_VLD, exp2Q[t], exp2V[t]);
      end
    end
  endtask

  task automatic test_busy_lockout();
    int n;
    a = 7'd3; cen = 1'b0; gwen = 1'b1; initReq = 1'b1;
    tick();
    initReq = 1'b0;
    total++;
    if (bus1.Q !== 8'h33 || bus1.Q_VLD !== 1'b1 || bus1.INIT_BUSY !== 1'b1) begin
      bad++; $display("[TB] FAIL req_rd1: got Q=%h vld=%b busy=%b want 33/1/1", bus1.Q, bus1.Q_VLD, bus1.INIT_BUSY);
    end
    a = 7'd9; gwen = 1'b0; wen = 8'h00; d = 8'h3C;
    tick();
    total++;
    if (bus2.Q !== 8'h33 || bus2.Q_VLD !== 1'b1 || bus2.INIT_BUSY !== 1'b1) begin
      bad++; $display("[TB] FAIL inflight_rd2: got Q=%h vld=%b busy=%b want 33/1/1", bus2.Q, bus2.Q_VLD, bus2.INIT_BUSY);
    end
    n = 2;
    while (bus2.INIT_BUSY === 1'b1 && n < 400) begin
      a = AW'($urandom_range(0, 127)); gwen = 1'b1;
      tick();
      total++;
      if (bus1.Q !== 8'h33 || bus2.Q !== 8'h33 || bus1.Q_VLD !== 1'b0 || bus2.Q_VLD !== 1'b0) begin
        bad++; $display("[TB] FAIL sweep_hold: got Q=%h/%h vld=%b/%b want 33/33 0/0", bus1.Q, bus2.Q, bus1.Q_VLD, bus2.Q_VLD);
      end
      if (bus2.INIT_BUSY === 1'b1) n++;
    end
    total++;
    if (n != 128) begin bad++; $display("[TB] FAIL lockout_len: got %0d want 128", n); end
    a = 7'd9; gwen = 1'b1; cen = 1'b0;
    tick();
    cen = 1'b1;
    total++;
    if (bus1.Q !== 8'hA5) begin bad++; $display("[TB] FAIL lockout_rd1: got %h want a5", bus1.Q); end
    tick();
    total++;
    if (bus2.Q !== 8'h00 || bus2.Q_VLD !== 1'b1) begin
      bad++; $display("[TB] FAIL lockout_rd2: got Q=%h vld=%b want 00/1", bus2.Q, bus2.Q_VLD);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n1, n2;
    idleInputs();
    initReq = 1'b1;
    tick();
    initReq = 1'b0;
    for (int c = 1; c < 50; c++) begin
      initReq = (c == 20);
      tick();
    end
    initReq = 1'b0;
    RST_B = 1'b0;
    tick();
    tick();
    total++;
    if (bus1.Q !== 8'h00 || bus2.Q !== 8'h00) begin
      bad++; $display("[TB] FAIL mid_rst_q: got %h/%h want 00/00", bus1.Q, bus2.Q);
    end
    RST_B = 1'b1;
    n1 = 0; n2 = 0;
    while ((bus1.INIT_BUSY === 1'b1 || bus2.INIT_BUSY === 1'b1) && n1 < 400 && n2 < 400) begin
      if (bus1.INIT_BUSY === 1'b1) n1++;
      if (bus2.INIT_BUSY === 1'b1) n2++;
      initReq = (n1 == 30);
      tick();
    end
    initReq = 1'b0;
    total++;
    if (n1 != 128 || n2 != 128) begin
      bad++; $display("[TB] FAIL mid_rst_len: got %0d/%0d want 128/128", n1, n2);
    end
  endtask

  task automatic test_hold_raw();
    a = 7'd7; cen = 1'b0; gwen = 1'b0; wen = 8'h00; d = 8'h12;
    tick();
    gwen = 1'b1; wen = '1;
    tick();
    cen = 1'b1;
    tick();
    for (int c = 0; c < 10; c++) begin
      tick();
      total++;
      if (bus1.Q !== 8'h12 || bus2.Q !== 8'h12 || bus1.Q_VLD !== 1'b0 || bus2.Q_VLD !== 1'b0) begin
        bad++; $display("[TB] FAIL hold_c%0d: got Q=%h/%h vld=%b/%b want 12/12 0/0", c, bus1.Q, bus2.Q, bus1.Q_VLD, bus2.Q_VLD);
      end
    end
    cen = 1'b0; gwen = 1'b0; wen = 8'h00; d = 8'h34;
    tick();
    gwen = 1'b1; wen = '1;
    tick();
    cen = 1'b1;
    total++;
    if (bus1.Q !== 8'h34 || bus1.Q_VLD !== 1'b1) begin
      bad++; $display("[TB] FAIL raw1: got Q=%h vld=%b want 34/1", bus1.Q, bus1.Q_VLD);
    end
    tick();
    total++;
    if (bus2.Q !== 8'h34 || bus2.Q_VLD !== 1'b1) begin
      bad++; $display("[TB] FAIL raw2: got Q=%h vld=%b want 34/1", bus2.Q, bus2.Q_VLD);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      cen     = ($urandom_range(0, 3) == 0);
      gwen    = $urandom_range(0, 1) == 1;
      a       = AW'($urandom_range(0, 15));
      wen     = DW'($urandom);
      d       = DW'($urandom);
      initReq = ($urandom_range(0, 149) == 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        logic [DW-1:0] q;
        logic          qv, bz;
        q  = (k == 0) ? bus1.Q : bus2.Q;
        qv = (k == 0) ? bus1.Q_VLD : bus2.Q_VLD;
        bz = (k == 0) ? bus1.INIT_BUSY : bus2.INIT_BUSY;
        total++;
        if (q !== mQ[k] || qv !== mQv[k] || bz !== (mPos[k] >= 0)) begin
          bad++; $display("[TB] FAIL rand%0d_c%0d: got Q=%h vld=%b busy=%b want Q=%h vld=%b busy=%b",
                          k + 1, c, q, qv, bz, mQ[k], mQv[k], mPos[k] >= 0);
        end
      end
    end
    idleInputs();
  endtask

  initial begin
    test_reset();
    test_masked_write();
    test_back_to_back();
    test_busy_lockout();
    test_reset_mid_sweep();
    test_hold_raw();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
